// File: rtl/req_ack_multi_monitor_if.sv
// Handshake bundle for the N-channel req/ack monitor: stimulus in, error reporting out.
interface req_ack_multi_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                      en;
    logic                      clr;
    logic [NUM_CH-1:0]         req;
    logic [NUM_CH-1:0]         ack;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         err_pulse;
    logic [2*NUM_CH-1:0]       err_code;
    logic [NUM_CH-1:0]         err_sticky;
    logic [CNT_W*NUM_CH-1:0]   err_cnt;

    modport master (
        output en, clr, req, ack,
        input  busy, err_pulse, err_code, err_sticky, err_cnt
    );

    modport slave (
        input  en, clr, req, ack,
        output busy, err_pulse, err_code, err_sticky, err_cnt
    );
endinterface

// File: rtl/req_ack_multi_monitor.sv
// N-channel req/ack handshake monitor: each channel checks that ack lands 1..MAX_LAT
// cycles after req and reports TIMEOUT / SPURIOUS / DROP one cycle after detection.
module req_ack_multi_monitor_ch #(
    parameter int MAX_LAT = 1,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             req,
    input  logic             ack,
    output logic             busy,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int LW = $clog2(MAX_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [1:0] C_TIMEOUT  = 2'd1;
    localparam logic [1:0] C_SPURIOUS = 2'd2;
    localparam logic [1:0] C_DROP     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic             pulse_q, pulse_d;
    logic [1:0]       code_q, code_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol;
    logic [1:0]       viol_code;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        viol      = 1'b0;
        viol_code = 2'd0;
        if (!en) begin
            state_d = S_IDLE;
            lat_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_d = S_WAIT;
                        lat_d   = LW'(1);
                    end
                    // In pulse mode nothing in IDLE can absorb an ack.
                    if (ack && (MODE == 0 || !req)) begin
                        viol      = 1'b1;
                        viol_code = C_SPURIOUS;
                    end
                end
                S_WAIT: begin
                    if (MODE == 1 && !req && !ack) begin
                        viol      = 1'b1;
                        viol_code = C_DROP;
                        state_d   = S_IDLE;
                        lat_d     = '0;
                    end else if (ack) begin
                        if (req) begin
                            state_d = (MODE == 0) ? S_WAIT : S_REL;
                            lat_d   = (MODE == 0) ? LW'(1) : '0;
                        end else begin
                            state_d = S_IDLE;
                            lat_d   = '0;
                        end
                    end else if (lat_q == LW'(MAX_LAT)) begin
                        viol      = 1'b1;
                        viol_code = C_TIMEOUT;
                        state_d   = (MODE == 1 && req) ? S_REL : S_IDLE;
                        lat_d     = '0;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                S_REL: begin
                    if (ack) begin
                        viol      = 1'b1;
                        viol_code = C_SPURIOUS;
                    end
                    if (!req) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end
            endcase
        end

        pulse_d  = viol;
        code_d   = viol_code;
        sticky_d = clr ? 1'b0 : (sticky_q | viol);
        if (clr)                 cnt_d = '0;
        else if (viol && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
        else                     cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            pulse_q  <= 1'b0;
            code_q   <= 2'd0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            pulse_q  <= pulse_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q == S_WAIT);
    assign err_pulse  = pulse_q;
    assign err_code   = code_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
endmodule

module req_ack_multi_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LAT = 1,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    req_ack_multi_monitor_if.slave  mon
);
    logic [NUM_CH-1:0]            busy_a;
    logic [NUM_CH-1:0]            pulse_a;
    logic [NUM_CH-1:0][1:0]       code_a;
    logic [NUM_CH-1:0]            sticky_a;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_a;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_ack_multi_monitor_ch #(
            .MAX_LAT (MAX_LAT),
            .MODE    (MODE),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (mon.en),
            .clr        (mon.clr),
            .req        (mon.req[i]),
            .ack        (mon.ack[i]),
            .busy       (busy_a[i]),
            .err_pulse  (pulse_a[i]),
            .err_code   (code_a[i]),
            .err_sticky (sticky_a[i]),
            .err_cnt    (cnt_a[i])
        );
    end

    assign mon.busy       = busy_a;
    assign mon.err_pulse  = pulse_a;
    assign mon.err_code   = code_a;
    assign mon.err_sticky = sticky_a;
    assign mon.err_cnt    = cnt_a;
endmodule

// File: tb/tb_req_ack_multi_monitor.sv
// Directed bench: three monitor configurations (pulse/lat1/2-bit cnt, pulse/lat3, level/lat4).
module tb_req_ack_multi_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    req_ack_multi_monitor_if #(.NUM_CH(4), .CNT_W(2)) if_a ();
    req_ack_multi_monitor_if #(.NUM_CH(4), .CNT_W(8)) if_b ();
    req_ack_multi_monitor_if #(.NUM_CH(4), .CNT_W(8)) if_c ();

    req_ack_multi_monitor #(.NUM_CH(4), .MAX_LAT(1), .MODE(0), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .mon(if_a.slave));
    req_ack_multi_monitor #(.NUM_CH(4), .MAX_LAT(3), .MODE(0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .mon(if_b.slave));
    req_ack_multi_monitor #(.NUM_CH(4), .MAX_LAT(4), .MODE(1), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .mon(if_c.slave));

    // Outputs read after tick reflect the cycle that just began.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_a.en = 1'b1; if_a.clr = 1'b0; if_a.req = '0; if_a.ack = '0;
        if_b.en = 1'b1; if_b.clr = 1'b0; if_b.req = '0; if_b.ack = '0;
        if_c.en = 1'b1; if_c.clr = 1'b0; if_c.req = '0; if_c.ack = '0;
        #12;
        checks++;
        if ({if_a.busy, if_a.err_pulse, if_a.err_code, if_a.err_sticky, if_a.err_cnt} !== '0) begin
            errors++; $display("FAIL reset_a got busy=%h pulse=%h cnt=%h exp 0", if_a.busy, if_a.err_pulse, if_a.err_cnt);
        end
        checks++;
        if ({if_c.busy, if_c.err_pulse, if_c.err_code, if_c.err_sticky, if_c.err_cnt} !== '0) begin
            errors++; $display("FAIL reset_c got busy=%h pulse=%h cnt=%h exp 0", if_c.busy, if_c.err_pulse, if_c.err_cnt);
        end
        #5 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pulse_ok();
        if_a.req[0] = 1'b1;
        tick();
        if_a.req[0] = 1'b0; if_a.ack[0] = 1'b1;
        checks++;
        if (if_a.busy[0] !== 1'b1) begin errors++; $display("FAIL t1_busy_t1 got %b exp 1", if_a.busy[0]); end
        tick();
        if_a.ack[0] = 1'b0;
        checks++;
        if (if_a.busy[0] !== 1'b0) begin errors++; $display("FAIL t1_busy_t2 got %b exp 0", if_a.busy[0]); end
        checks++;
        if (if_a.err_pulse !== 4'h0) begin errors++; $display("FAIL t1_pulse got %h exp 0", if_a.err_pulse); end
        tick();
        checks++;
        if (if_a.err_pulse !== 4'h0) begin errors++; $display("FAIL t1_pulse_t3 got %h exp 0", if_a.err_pulse); end
    endtask

    task automatic test_timeout();
        if_b.req[1] = 1'b1;
        tick();
        if_b.req[1] = 1'b0;
        tick(); tick();
        checks++;
        if (if_b.err_pulse[1] !== 1'b0) begin errors++; $display("FAIL t2_early_pulse got %b exp 0", if_b.err_pulse[1]); end
        tick();
        checks++;
        if (if_b.err_pulse[1] !== 1'b1 || if_b.err_code[3:2] !== 2'd1) begin
            errors++; $display("FAIL t2_timeout got pulse=%b code=%0d exp pulse=1 code=1", if_b.err_pulse[1], if_b.err_code[3:2]);
        end
        checks++;
        if (if_b.err_cnt[15:8] !== 8'd1 || if_b.err_sticky[1] !== 1'b1) begin
            errors++; $display("FAIL t2_cnt got cnt=%0d sticky=%b exp cnt=1 sticky=1", if_b.err_cnt[15:8], if_b.err_sticky[1]);
        end
        checks++;
        if (if_b.busy[1] !== 1'b0) begin errors++; $display("FAIL t2_busy got %b exp 0", if_b.busy[1]); end
        tick();
        checks++;
        if (if_b.err_pulse[1] !== 1'b0) begin errors++; $display("FAIL t2_pulse_width got %b exp 0", if_b.err_pulse[1]); end
    endtask

    task automatic test_level_drop_spurious();
        if_c.req[2] = 1'b1;
        tick();
        tick();
        if_c.req[2] = 1'b0;
        tick();
        checks++;
        if (if_c.err_pulse[2] !== 1'b1 || if_c.err_code[5:4] !== 2'd3) begin
            errors++; $display("FAIL t3_drop got pulse=%b code=%0d exp pulse=1 code=3", if_c.err_pulse[2], if_c.err_code[5:4]);
        end
        tick();
        checks++;
        if (if_c.err_pulse[2] !== 1'b0) begin errors++; $display("FAIL t3_quiet got %b exp 0", if_c.err_pulse[2]); end
        if_c.ack[2] = 1'b1;
        tick();
        if_c.ack[2] = 1'b0;
        checks++;
        if (if_c.err_pulse[2] !== 1'b1 || if_c.err_code[5:4] !== 2'd2) begin
            errors++; $display("FAIL t3_spurious got pulse=%b code=%0d exp pulse=1 code=2", if_c.err_pulse[2], if_c.err_code[5:4]);
        end
        checks++;
        if (if_c.err_cnt[23:16] !== 8'd2) begin errors++; $display("FAIL t3_cnt got %0d exp 2", if_c.err_cnt[23:16]); end
        // Held level req acked then released: RELEASE ack is SPURIOUS.
        if_c.req[2] = 1'b1;
        tick();
        if_c.ack[2] = 1'b1;
        tick();
        checks++;
        if (if_c.err_pulse[2] !== 1'b0) begin errors++; $display("FAIL t3_clean_ack got %b exp 0", if_c.err_pulse[2]); end
        tick();
        if_c.ack[2] = 1'b0; if_c.req[2] = 1'b0;
        checks++;
        if (if_c.err_pulse[2] !== 1'b1 || if_c.err_code[5:4] !== 2'd2) begin
            errors++; $display("FAIL t3_release_ack got pulse=%b code=%0d exp pulse=1 code=2", if_c.err_pulse[2], if_c.err_code[5:4]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        if_a.req[3] = 1'b1;
        tick();
        if_a.ack[3] = 1'b1;
        tick();
        if_a.req[3] = 1'b0;
        checks++;
        if (if_a.busy[3] !== 1'b1 || if_a.err_pulse[3] !== 1'b0) begin
            errors++; $display("FAIL t4_second_txn got busy=%b pulse=%b exp busy=1 pulse=0", if_a.busy[3], if_a.err_pulse[3]);
        end
        tick();
        if_a.ack[3] = 1'b0;
        checks++;
        if (if_a.busy[3] !== 1'b0 || if_a.err_pulse[3] !== 1'b0) begin
            errors++; $display("FAIL t4_done got busy=%b pulse=%b exp busy=0 pulse=0", if_a.busy[3], if_a.err_pulse[3]);
        end
        tick();
        checks++;
        if (if_a.err_pulse[3] !== 1'b0 || if_a.err_cnt[7:6] !== 2'd0) begin
            errors++; $display("FAIL t4_noerr got pulse=%b cnt=%0d exp 0", if_a.err_pulse[3], if_a.err_cnt[7:6]);
        end
    endtask

    task automatic test_saturate_clr();
        for (int k = 1; k <= 5; k++) begin
            if_a.req[0] = 1'b1;
            tick();
            if_a.req[0] = 1'b0;
            tick();
            checks++;
            if (if_a.err_cnt[1:0] !== ((k > 3) ? 2'd3 : 2'(k)) || if_a.err_code[1:0] !== 2'd1) begin
                errors++; $display("FAIL t5_sat k=%0d got cnt=%0d code=%0d exp cnt=%0d code=1", k, if_a.err_cnt[1:0], if_a.err_code[1:0], (k > 3) ? 3 : k);
            end
        end
        checks++;
        if (if_a.err_sticky[0] !== 1'b1) begin errors++; $display("FAIL t5_sticky got %b exp 1", if_a.err_sticky[0]); end
        if_a.req[0] = 1'b1;
        tick();
        if_a.req[0] = 1'b0; if_a.clr = 1'b1;
        tick();
        if_a.clr = 1'b0;
        checks++;
        if (if_a.err_pulse[0] !== 1'b1 || if_a.err_cnt[1:0] !== 2'd0 || if_a.err_sticky[0] !== 1'b0) begin
            errors++; $display("FAIL t5_clr got pulse=%b cnt=%0d sticky=%b exp pulse=1 cnt=0 sticky=0", if_a.err_pulse[0], if_a.err_cnt[1:0], if_a.err_sticky[0]);
        end
        tick();
    endtask

    task automatic test_async_reset_and_en();
        if_a.req = 4'hF; if_b.req = 4'hF; if_c.req = 4'hF;
        tick();
        checks++;
        if (if_a.busy !== 4'hF || if_b.busy !== 4'hF || if_c.busy !== 4'hF) begin
            errors++; $display("FAIL t6_all_wait got a=%h b=%h c=%h exp f", if_a.busy, if_b.busy, if_c.busy);
        end
        if_a.req = '0; if_b.req = '0; if_c.req = '0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_b.busy, if_b.err_sticky, if_b.err_cnt, if_c.busy, if_c.err_sticky, if_c.err_cnt} !== '0) begin
            errors++; $display("FAIL t6_async got b_busy=%h b_cnt=%h c_cnt=%h exp 0", if_b.busy, if_b.err_cnt, if_c.err_cnt);
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ((if_a.err_pulse | if_b.err_pulse | if_c.err_pulse) !== 4'h0) begin
            errors++; $display("FAIL t6_no_err got a=%h b=%h c=%h exp 0", if_a.err_pulse, if_b.err_pulse, if_c.err_pulse);
        end
        if_b.req[0] = 1'b1;
        tick();
        if_b.req[0] = 1'b0; if_b.en = 1'b0;
        tick();
        checks++;
        if (if_b.busy[0] !== 1'b0) begin errors++; $display("FAIL t6_en_busy got %b exp 0", if_b.busy[0]); end
        if_b.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (if_b.err_pulse[0] !== 1'b0 || if_b.err_cnt[7:0] !== 8'd0) begin
                errors++; $display("FAIL t6_en_no_timeout k=%0d got pulse=%b cnt=%0d exp 0", k, if_b.err_pulse[0], if_b.err_cnt[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse_ok();
        test_timeout();
        test_level_drop_spurious();
        test_back_to_back();
        test_saturate_clr();
        test_async_reset_and_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
